// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully connected layer datapath.
package nn_pkg;
  localparam int DW   = 8;
  localparam int FRAC = 4;

  typedef enum logic [1:0] {PH_LOAD, PH_MAC, PH_BIAS, PH_ACT} phase_e;

  // Sum of NO_IPN full products plus a shifted bias can never overflow this width.
  function automatic int acc_w(input int dw, input int ipn);
    return 2 * dw + $clog2(ipn) + 1;
  endfunction

  // Drop fractional bits (toward -inf), clamp negatives to 0, optionally clamp to the DW max.
  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] acc, input int frac,
                                                  input int dw, input bit sat);
    logic signed [63:0] r;
    logic signed [63:0] lim;
    r   = acc >>> frac;
    lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (r < 0) r = '0;
    else if (sat && (r > lim)) r = lim;
    return r;
  endfunction
endpackage

// File: rtl/neuron_lane.sv
// One MAC lane: a weight column buffer and a wide signed accumulator.
module neuron_lane
  import nn_pkg::*;
#(
  parameter int NO_IPN = 4,
  parameter int DW     = nn_pkg::DW,
  parameter int FRAC   = nn_pkg::FRAC,
  parameter int ACC_W  = acc_w(DW, NO_IPN),
  localparam int IW    = $clog2(NO_IPN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [DW-1:0]    w_in,
  input  logic             mac_step,
  input  logic [IW-1:0]    rd_idx,
  input  logic [DW-1:0]    x_in,
  input  logic             bias_step,
  input  logic [DW-1:0]    bias_in,
  input  logic             clr,
  output logic [ACC_W-1:0] acc
);
  logic [NO_IPN-1:0][DW-1:0] w_buf_q, w_buf_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic signed [2*DW-1:0]    prod;
  logic [DW-1:0]             w_sel;

  always_comb begin
    w_sel = w_buf_q[rd_idx];
    prod  = $signed({{DW{x_in[DW-1]}}, x_in}) * $signed({{DW{w_sel[DW-1]}}, w_sel});
    w_buf_d = w_buf_q;
    if (wr_en) w_buf_d[wr_idx] = w_in;
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (mac_step)
      acc_d = acc_q + {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
    else if (bias_step)
      // bias is Q.FRAC; shift it up to the Q.2FRAC scale of the products
      acc_d = acc_q + {{(ACC_W - DW - FRAC){bias_in[DW-1]}}, bias_in, {FRAC{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_buf_q <= '0;
      acc_q   <= '0;
    end else begin
      w_buf_q <= w_buf_d;
      acc_q   <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/layer_datapath.sv
// Fully connected layer datapath: parallel MAC lanes, serial bias/ReLU/emit.
// Define OUT_SAT_EN to saturate outputs above the signed DW maximum instead of truncating.
module layer_datapath
  import nn_pkg::*;
#(
  parameter int NO_NPL = 4,
  parameter int NO_IPN = 4,
  parameter int DW     = nn_pkg::DW,
  parameter int FRAC   = nn_pkg::FRAC,
  localparam int IW    = $clog2(NO_IPN),
  localparam int NW    = $clog2(NO_NPL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_x,
  input  logic [NO_NPL*DW-1:0] in_w,
  input  logic [NO_NPL*DW-1:0] bias,
  input  logic                 mac_en,
  input  logic                 bias_add_en,
  input  logic                 act_fn_en,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [NW-1:0]        out_idx,
  output logic                 layer_done,
  output logic                 protocol_err
);
  localparam int ACC_W = acc_w(DW, NO_IPN);
`ifdef OUT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  phase_e                    phase_q, phase_d;
  logic [IW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]             b_ptr_q, b_ptr_d, a_ptr_q, a_ptr_d;
  logic                      load_full_q, load_full_d;
  logic [NO_IPN-1:0][DW-1:0] x_buf_q, x_buf_d;
  logic                      out_valid_q, out_valid_d, layer_done_q, layer_done_d;
  logic [DW-1:0]             out_data_q, out_data_d;
  logic [NW-1:0]             out_idx_q, out_idx_d;
  logic                      err_q, err_d;
  logic                      multi, mac_ok, bias_ok, act_ok, accept;
  logic [NO_NPL-1:0][ACC_W-1:0] lane_acc;
  logic [ACC_W-1:0]          acc_sel;

  for (genvar n = 0; n < NO_NPL; n++) begin : g_lane
    neuron_lane #(.NO_IPN(NO_IPN), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (accept),
      .wr_idx    (wr_ptr_q),
      .w_in      (in_w[n*DW +: DW]),
      .mac_step  (mac_ok),
      .rd_idx    (rd_ptr_q),
      .x_in      (x_buf_q[rd_ptr_q]),
      .bias_step (bias_ok && (b_ptr_q == NW'(n))),
      .bias_in   (bias[n*DW +: DW]),
      .clr       (layer_done_q),
      .acc       (lane_acc[n])
    );
  end

  always_comb begin
    multi   = $countones({mac_en, bias_add_en, act_fn_en}) > 1;
    mac_ok  = mac_en      && !multi && (phase_q == PH_MAC);
    bias_ok = bias_add_en && !multi && (phase_q == PH_BIAS);
    act_ok  = act_fn_en   && !multi && (phase_q == PH_ACT);
    accept  = in_valid && !load_full_q && (phase_q == PH_LOAD);
    acc_sel = lane_acc[a_ptr_q];

    phase_d      = phase_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    b_ptr_d      = b_ptr_q;
    a_ptr_d      = a_ptr_q;
    load_full_d  = load_full_q;
    x_buf_d      = x_buf_q;
    out_valid_d  = 1'b0;
    layer_done_d = 1'b0;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    // Any strobe that does not qualify is a violation and is dropped.
    err_d = err_q | (mac_en && !mac_ok) | (bias_add_en && !bias_ok) | (act_fn_en && !act_ok);

    case (phase_q)
      PH_LOAD: if (accept) begin
        x_buf_d[wr_ptr_q] = in_x;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == IW'(NO_IPN - 1)) begin
          wr_ptr_d    = '0;
          load_full_d = 1'b1;
          phase_d     = PH_MAC;
        end
      end
      PH_MAC: if (mac_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_q == IW'(NO_IPN - 1)) begin
          rd_ptr_d = '0;
          phase_d  = PH_BIAS;
        end
      end
      PH_BIAS: if (bias_ok) begin
        b_ptr_d = b_ptr_q + 1'b1;
        if (b_ptr_q == NW'(NO_NPL - 1)) begin
          b_ptr_d = '0;
          phase_d = PH_ACT;
        end
      end
      PH_ACT: if (act_ok) begin
        out_valid_d = 1'b1;
        out_idx_d   = a_ptr_q;
        out_data_d  = DW'(relu_sat({{(64 - ACC_W){acc_sel[ACC_W-1]}}, acc_sel}, FRAC, DW, SAT));
        a_ptr_d     = a_ptr_q + 1'b1;
        if (a_ptr_q == NW'(NO_NPL - 1)) begin
          a_ptr_d      = '0;
          layer_done_d = 1'b1;
          phase_d      = PH_LOAD;
        end
      end
      default: phase_d = PH_LOAD;
    endcase

    // load_full stays set through the layer_done cycle so in_ready rises one cycle later.
    if (layer_done_q) load_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      b_ptr_q      <= '0;
      a_ptr_q      <= '0;
      load_full_q  <= 1'b0;
      x_buf_q      <= '0;
      out_valid_q  <= 1'b0;
      layer_done_q <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      b_ptr_q      <= b_ptr_d;
      a_ptr_q      <= a_ptr_d;
      load_full_q  <= load_full_d;
      x_buf_q      <= x_buf_d;
      out_valid_q  <= out_valid_d;
      layer_done_q <= layer_done_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      err_q        <= err_d;
    end
  end

  assign in_ready     = !load_full_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign layer_done   = layer_done_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_layer_datapath.sv
// Scoreboard bench for layer_datapath (NO_NPL=4, NO_IPN=4, DW=8, FRAC=4).
module tb_layer_datapath;
  localparam int NPL = 4;
  localparam int IPN = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0, mac_en = 1'b0, bias_add_en = 1'b0, act_fn_en = 1'b0;
  logic [7:0]      in_x = '0;
  logic [NPL*8-1:0] in_w = '0, bias = '0;
  logic            in_ready, out_valid, layer_done, protocol_err;
  logic [7:0]      out_data;
  logic [1:0]      out_idx;

  typedef struct { logic [7:0] data; logic [1:0] idx; logic last; } exp_t;
  exp_t sb_q[$];
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  layer_datapath #(.NO_NPL(NPL), .NO_IPN(IPN), .DW(8), .FRAC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .bias(bias), .mac_en(mac_en), .bias_add_en(bias_add_en), .act_fn_en(act_fn_en),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .layer_done(layer_done),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: constant x and per-lane weight over all IPN inputs, then bias, shift, ReLU.
  function automatic logic [7:0] model(input byte x, input byte w, input byte b);
    int acc, r;
    logic [31:0] rv;
    acc = IPN * int'(x) * int'(w) + int'(b) * 16;
    r   = acc >>> 4;
    if (r < 0) r = 0;
`ifdef OUT_SAT_EN
    if (r > 127) r = 127;
`endif
    rv = r;
    return rv[7:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_idx", out_idx, e.idx);
          chk("layer_done", layer_done, e.last);
        end
      end else if (layer_done) chk("done_alone", layer_done, 1'b0);
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 0; mac_en = 0; bias_add_en = 0; act_fn_en = 0;
  endtask

  task automatic setup(input byte x, input byte w [NPL], input byte b);
    in_x = x;
    for (int n = 0; n < NPL; n++) begin
      in_w[n*8 +: 8] = w[n];
      bias[n*8 +: 8] = b;
    end
  endtask

  task automatic load(input int n, output int acc_cnt);
    acc_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1;
      if (in_ready) acc_cnt++;
    end
    idle();
  endtask

  task automatic strobe(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mac_en = (which == 0); bias_add_en = (which == 1); act_fn_en = (which == 2);
    end
    idle();
  endtask

  task automatic act_all(input byte x, input byte w [NPL], input byte b);
    for (int i = 0; i < NPL; i++) begin
      exp_t e;
      @(negedge clk);
      act_fn_en = 1;
      e.data = model(x, w[i], b);
      e.idx  = 2'(i);
      e.last = (i == NPL - 1);
      sb_q.push_back(e);
    end
    idle();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!layer_done && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", layer_done, 1'b1);
    chk("ready_in_done", in_ready, 1'b0);
  endtask

  task automatic run_layer(input byte x, input byte w [NPL], input byte b);
    int c;
    setup(x, w, b);
    load(IPN, c);
    chk("accepts", c, IPN);
    strobe(0, IPN);
    strobe(1, NPL);
    act_all(x, w, b);
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    in_valid = 0; mac_en = 0; bias_add_en = 0; act_fn_en = 0;
    @(negedge clk); @(negedge clk); rst = 0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_idx", out_idx, 2'd0);
    chk("rst_done", layer_done, 1'b0);
    chk("rst_err", protocol_err, 1'b0);
  endtask

  initial begin
    byte w1 [NPL] = '{8'sh08, 8'sh08, 8'sh08, 8'sh08};
    byte w2 [NPL] = '{8'sh08, 8'sh08, -8'sh08, 8'sh08};
    byte w3 [NPL] = '{8'sh7F, 8'sh7F, 8'sh7F, 8'sh7F};
    int c;

    do_reset();
    run_layer(8'sh10, w1, 8'sh10);
    run_layer(8'sh10, w2, 8'sh10);
    run_layer(8'sh7F, w3, 8'sh00);

    // back-to-back: in_ready must be up the cycle after layer_done
    setup(8'sh10, w1, 8'sh10);
    @(negedge clk);
    chk("b2b_ready", in_ready, 1'b1);
    in_valid = 1;
    for (int i = 1; i < IPN; i++) @(negedge clk);
    idle();
    strobe(0, IPN);
    strobe(1, NPL);
    act_all(8'sh10, w1, 8'sh10);
    wait_done();

    // overload and an out-of-phase strobe that must leave acc untouched
    setup(8'sh10, w1, 8'sh10);
    load(6, c);
    chk("over_accepts", c, IPN);
    chk("over_ready", in_ready, 1'b0);
    chk("err_before", protocol_err, 1'b0);
    strobe(1, 1);
    chk("err_bias_in_mac", protocol_err, 1'b1);
    strobe(0, IPN);
    strobe(1, NPL);
    act_all(8'sh10, w1, 8'sh10);
    wait_done();
    chk("err_sticky", protocol_err, 1'b1);
    do_reset();

    // reset mid-MAC discards the partial layer
    setup(8'sh7F, w3, 8'sh10);
    load(IPN, c);
    strobe(0, 2);
    do_reset();
    repeat (3) @(negedge clk);
    run_layer(8'sh10, w1, 8'sh10);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
